// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg
//   Shared definitions for the multiplier result sequencer: the FSM state
//   encoding, default widths/timeouts and a counter-width helper.
package mul_seq_pkg;

  localparam int DATA_W_DEFAULT      = 32;
  localparam int TIMEOUT_CYC_DEFAULT = 40;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PROD = 3'd1,
    XFER_LO   = 3'd2,
    XFER_HI   = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_wdog.sv
// mul_wdog
//   Watchdog cycle counter for the product wait. Counts enabled cycles,
//   restarts on clear, and raises tc when the count reaches TIMEOUT_CYC-1.
// Ports:
//   clk   in  clock, rising edge
//   clr   in  synchronous active-high reset
//   clear in  restart the count at zero
//   en    in  count this cycle
//   tc    out terminal count (count == TIMEOUT_CYC-1)
module mul_wdog
  import mul_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = cnt_width(TIMEOUT_CYC);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_r;

  // Cycle counter: reset, restart, or advance while enabled.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != TC_VAL)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == TC_VAL);

endmodule

// File: rtl/mul_result_sequencer.sv
// mul_result_sequencer
//   Downstream stage of the Booth multiplier. Starts a multiply, accepts the
//   2*DATA_W product over valid/ready, latches it into z_reg and then moves
//   the low and high halves onto the shared bus in two granted beats,
//   strobing lo_en / hi_en. A watchdog sets the sticky err flag when no
//   product arrives within TIMEOUT_CYC cycles.
// Ports:
//   clk, clr               clock and synchronous active-high reset
//   op_start               request from control unit (honoured only in IDLE)
//   mul_start              one-cycle start pulse to the multiplier
//   prod, prod_valid,
//   prod_ready             product handshake from the multiplier
//   bus_req, bus_gnt,
//   bus_out                shared-bus request/grant and drive (0 unless granted)
//   lo_en, hi_en           LO / HI register load strobes
//   busy, done, err        status: not IDLE, completion pulse, sticky timeout
// Optional build macro MUL_FLAGS_EN adds flag_z (product == 0) and
// flag_n (product MSB), captured with z_reg.
module mul_result_sequencer
  import mul_seq_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                op_start,
  output logic                mul_start,
  input  logic [2*DATA_W-1:0] prod,
  input  logic                prod_valid,
  output logic                prod_ready,
  output logic                bus_req,
  input  logic                bus_gnt,
  output logic [DATA_W-1:0]   bus_out,
  output logic                lo_en,
  output logic                hi_en,
  output logic                busy,
  output logic                done,
  output logic                err
`ifdef MUL_FLAGS_EN
  ,
  output logic                flag_z,
  output logic                flag_n
`endif
);

  state_t state_r;
  state_t state_s;

  logic [2*DATA_W-1:0] z_reg;
  logic mul_start_r;
  logic err_r;
  logic tc_s;
  logic start_s;
  logic capture_s;
  logic timeout_s;
  logic wdog_clear_s;
  logic wdog_en_s;

  assign start_s      = (state_r == IDLE) && op_start;
  assign capture_s    = (state_r == WAIT_PROD) && prod_valid;
  // A valid on the terminal cycle takes priority over the timeout.
  assign timeout_s    = (state_r == WAIT_PROD) && !prod_valid && tc_s;
  assign wdog_clear_s = (state_r != WAIT_PROD);
  assign wdog_en_s    = (state_r == WAIT_PROD) && !prod_valid;

  mul_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk  (clk),
    .clr  (clr),
    .clear(wdog_clear_s),
    .en   (wdog_en_s),
    .tc   (tc_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (op_start) state_s = WAIT_PROD;
        else          state_s = IDLE;
      end
      WAIT_PROD: begin
        if (prod_valid) state_s = XFER_LO;
        else if (tc_s)  state_s = IDLE;
        else            state_s = WAIT_PROD;
      end
      XFER_LO: begin
        if (bus_gnt) state_s = XFER_HI;
        else         state_s = XFER_LO;
      end
      XFER_HI: begin
        if (bus_gnt) state_s = DONE;
        else         state_s = XFER_HI;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Product capture, start pulse and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (clr) begin
      z_reg       <= '0;
      mul_start_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      mul_start_r <= start_s;
      if (capture_s) z_reg <= prod;
      else           z_reg <= z_reg;
      if (timeout_s) err_r <= 1'b1;
      else           err_r <= err_r;
    end
  end

  // Output decode: status from registered state, bus beats gated by grant.
  always_comb begin
    bus_out    = '0;
    lo_en      = 1'b0;
    hi_en      = 1'b0;
    bus_req    = 1'b0;
    prod_ready = 1'b0;
    busy       = (state_r != IDLE);
    done       = 1'b0;
    case (state_r)
      IDLE:      prod_ready = 1'b0;
      WAIT_PROD: prod_ready = 1'b1;
      XFER_LO: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          bus_out = z_reg[DATA_W-1:0];
          lo_en   = 1'b1;
        end else begin
          bus_out = '0;
          lo_en   = 1'b0;
        end
      end
      XFER_HI: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          bus_out = z_reg[2*DATA_W-1:DATA_W];
          hi_en   = 1'b1;
        end else begin
          bus_out = '0;
          hi_en   = 1'b0;
        end
      end
      DONE:    done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  assign mul_start = mul_start_r;
  assign err       = err_r;

`ifdef MUL_FLAGS_EN
  logic flag_z_r;
  logic flag_n_r;

  // Result flags, captured alongside z_reg.
  always_ff @(posedge clk) begin
    if (clr) begin
      flag_z_r <= 1'b0;
      flag_n_r <= 1'b0;
    end else if (capture_s) begin
      flag_z_r <= (prod == '0);
      flag_n_r <= prod[2*DATA_W-1];
    end else begin
      flag_z_r <= flag_z_r;
      flag_n_r <= flag_n_r;
    end
  end

  assign flag_z = flag_z_r;
  assign flag_n = flag_n_r;
`endif

endmodule

// File: tb/tb_mul_result_sequencer.sv
// tb_mul_result_sequencer
//   Scoreboard bench: each operation pushes its expected events (start pulse,
//   LO beat, HI beat, done) with the cycle they must appear in; a monitor
//   pops and compares whenever the DUT strobes one of them.
module tb_mul_result_sequencer;

  localparam int DW = 32;
  localparam int TO = 40;

  localparam int K_MST  = 0;
  localparam int K_LO   = 1;
  localparam int K_HI   = 2;
  localparam int K_DONE = 3;

  logic            clk = 1'b0;
  logic            clr = 1'b1;
  logic            op_start = 1'b0;
  logic            mul_start;
  logic [2*DW-1:0] prod = '0;
  logic            prod_valid = 1'b0;
  logic            prod_ready;
  logic            bus_req;
  logic            bus_gnt = 1'b0;
  logic [DW-1:0]   bus_out;
  logic            lo_en;
  logic            hi_en;
  logic            busy;
  logic            done;
  logic            err;
`ifdef MUL_FLAGS_EN
  logic            flag_z;
  logic            flag_n;
`endif

  mul_result_sequencer #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .clr       (clr),
    .op_start  (op_start),
    .mul_start (mul_start),
    .prod      (prod),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .bus_out   (bus_out),
    .lo_en     (lo_en),
    .hi_en     (hi_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef MUL_FLAGS_EN
    ,
    .flag_z    (flag_z),
    .flag_n    (flag_n)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;
    logic        fz;
    logic        fn;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  err_model = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [31:0] data, input int at,
                         input logic [63:0] p);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = at;
    e.fz   = (p == 64'd0);
    e.fn   = p[63];
    sb.push_back(e);
  endtask

  task automatic pop_chk(input int kind, input string name);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s at cycle %0d: got unexpected strobe, expected none", name, cyc);
    end else begin
      e = sb.pop_front();
      chk({name, "_kind"}, 64'(kind), 64'(e.kind));
      chk({name, "_cycle"}, 64'(cyc), 64'(e.cyc));
      if (kind == K_LO || kind == K_HI) begin
        chk({name, "_data"}, 64'(bus_out), 64'(e.data));
        chk({name, "_gnt"}, 64'(bus_gnt), 64'd1);
`ifdef MUL_FLAGS_EN
        chk({name, "_flag_z"}, 64'(flag_z), 64'(e.fz));
        chk({name, "_flag_n"}, 64'(flag_n), 64'(e.fn));
`endif
      end
    end
  endtask

  // Monitor: sample away from the active edge and consume scoreboard events.
  initial forever begin
    @(negedge clk);
    if (!clr) begin
      if (mul_start) pop_chk(K_MST, "mul_start");
      if (lo_en)     pop_chk(K_LO, "lo_beat");
      if (hi_en)     pop_chk(K_HI, "hi_beat");
      if (done)      pop_chk(K_DONE, "done");
      if (!lo_en && !hi_en) chk("bus_out_idle", 64'(bus_out), 64'd0);
      if (!busy) begin
        chk("prod_ready_idle", 64'(prod_ready), 64'd0);
        chk("bus_req_idle", 64'(bus_req), 64'd0);
      end
    end
  end

  task automatic check_idle(input string name);
    chk({name, "_mul_start"}, 64'(mul_start), 64'd0);
    chk({name, "_prod_ready"}, 64'(prod_ready), 64'd0);
    chk({name, "_bus_req"}, 64'(bus_req), 64'd0);
    chk({name, "_bus_out"}, 64'(bus_out), 64'd0);
    chk({name, "_lo_en"}, 64'(lo_en), 64'd0);
    chk({name, "_hi_en"}, 64'(hi_en), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_err"}, 64'(err), 64'd0);
`ifdef MUL_FLAGS_EN
    chk({name, "_flag_z"}, 64'(flag_z), 64'd0);
    chk({name, "_flag_n"}, 64'(flag_n), 64'd0);
`endif
  endtask

  task automatic do_reset();
    clr = 1'b1;
    op_start = 1'b0;
    prod_valid = 1'b0;
    bus_gnt = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    clr = 1'b0;
    sb.delete();
    err_model = 1'b0;
    check_idle("reset");
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      op_start   = 1'b0;
      prod_valid = 1'($urandom);
      prod       = {$urandom, $urandom};
      bus_gnt    = 1'($urandom);
    end
  endtask

  // One operation, starting in the current cycle (cycle 0). k = product valid
  // cycle (outside 1..TO means none), stalls in cycles per beat, clr_at = cycle
  // to assert clr (negative for none). op_start is also pulsed at cycle 2,
  // when the sequencer is always busy, and must be ignored.
  task automatic run_op(input logic [63:0] p, input int k, input int lo_st,
                        input int hi_st, input int clr_at);
    int t0;
    int len;
    int lo_s;
    int hi_s;
    bit complete;
    t0 = cyc;
    complete = (k >= 1) && (k <= TO);
    lo_s = k + 1;
    hi_s = k + 2 + lo_st;
    push_ev(K_MST, 32'd0, t0 + 1, p);
    if (complete) begin
      push_ev(K_LO, p[31:0], t0 + lo_s + lo_st, p);
      push_ev(K_HI, p[63:32], t0 + hi_s + hi_st, p);
      push_ev(K_DONE, 32'd0, t0 + hi_s + hi_st + 1, p);
      len = k + lo_st + hi_st + 6;
    end else begin
      len = TO + 3;
    end
    for (int c = 0; c < len; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (clr_at >= 0 && c == clr_at + 1) begin
        clr = 1'b0;
        sb.delete();
        err_model = 1'b0;
        check_idle("after_clr");
        break;
      end
      op_start   = (c == 0) || (c == 2);
      prod_valid = complete && (c == k);
      prod       = (c == k) ? p : {$urandom, $urandom};
      if (!complete || c < lo_s)              bus_gnt = 1'($urandom);
      else if (c < lo_s + lo_st)              bus_gnt = 1'b0;
      else if (c >= hi_s && c < hi_s + hi_st) bus_gnt = 1'b0;
      else                                    bus_gnt = 1'b1;
      if (c == clr_at) begin
        clr = 1'b1;
        bus_gnt = 1'b0;
      end
      if (!complete && c == TO) chk("err_before_timeout", 64'(err), 64'(err_model));
      if (!complete && c == TO + 1) begin
        err_model = 1'b1;
        chk("err_at_timeout", 64'(err), 64'd1);
        chk("busy_after_timeout", 64'(busy), 64'd0);
      end
    end
    op_start   = 1'b0;
    prod_valid = 1'b0;
    chk("err_after_op", 64'(err), 64'(err_model));
  endtask

  initial begin
    do_reset();
    // Basic transfer.
    run_op(64'h0000_0001_FFFF_FFFE, 3, 0, 0, -1);
    idle(3);
    // Bus stall in both beats.
    run_op(64'h1234_5678_9ABC_DEF0, 2, 3, 2, -1);
    idle(2);
    // Timeout, then a normal operation while err stays set.
    run_op(64'hDEAD_BEEF_0000_0000, 0, 0, 0, -1);
    idle(2);
    run_op({$urandom, $urandom}, 2, 0, 0, -1);
    idle(2);
    // Valid on the final WAIT_PROD cycle.
    do_reset();
    run_op(64'hCAFE_F00D_0123_4567, TO, 1, 0, -1);
    idle(2);
    // clr during XFER_HI.
    run_op(64'h5555_AAAA_3333_CCCC, 2, 0, 3, 4);
    idle(2);
    // Flag patterns.
    run_op(64'h0000_0000_0000_0000, 1, 0, 0, -1);
    idle(1);
    run_op(64'h8000_0000_0000_0000, 4, 0, 1, -1);
    idle(1);
    // Randomized operations.
    for (int i = 0; i < 20; i++) begin
      run_op({$urandom, $urandom}, int'($urandom_range(1, 8)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
      idle(int'($urandom_range(0, 3)));
    end
    idle(3);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
